sample_frame_sequencer: RTL
===========================

// Module: sample_frame_sequencer
// PURPOSE
//   Parametrised input-sample sequencer for the FFT front end; successor to the fixed 48-sample input counter.
//   Accepts samples over a valid/ready handshake and counts them into frames of FRAME_LEN.
//   Hands each full frame to the FFT core over a frame_valid/fft_ready handshake.
//   Supports overlapped framing (HOP_LEN < FRAME_LEN), frame numbering and sticky overrun detection.
// PARAMETERS
//   FRAME_LEN    48                        samples per frame; legal range >= 2
//   HOP_LEN      48                        new samples per frame; 1 <= HOP_LEN <= FRAME_LEN; FRAME_LEN-HOP_LEN samples retained
//   CNT_W        $clog2(FRAME_LEN+1)       width of sample index
//   FRAME_CNT_W  8                         width of frame number counter (wraps)
// PORTS
//   clk          in   1            system clock, rising edge
//   n_reset      in   1            asynchronous active-low reset
//   enable       in   1            sequencer run enable
//   sync_clear   in   1            synchronous clear of all counters/flags
//   in_valid     in   1            upstream sample valid
//   in_ready     out  1            sequencer can accept a sample
//   sample_shift out  1            = in_valid & in_ready; clocks input shift register (combinational)
//   sample_idx   out  CNT_W        samples currently held in frame (0..FRAME_LEN)
//   frame_valid  out  1            full frame available to FFT core
//   fft_ready    in   1            FFT core accepts frame
//   frame_strobe out  1            = frame_valid & fft_ready; one-cycle frame transfer pulse
//   frame_num    out  FRAME_CNT_W  frames transferred since reset/clear, mod 2^FRAME_CNT_W
//   overrun      out  1            sticky: a sample was offered while in FULL
// BEHAVIOUR
//   Reset (n_reset=0, async): state=IDLE, sample_idx=0, frame_num=0, overrun=0.
//   Reset outputs: in_ready=0, frame_valid=0.
//   States: IDLE, FILL, FULL (registered, one-hot or binary at implementer's choice).
//   IDLE:
//     in_ready=0, frame_valid=0.
//     enable=1 -> FILL next cycle with sample_idx unchanged (0 after reset/clear).
//   FILL:
//     in_ready=1.
//     An accept (in_valid=1) increments sample_idx next edge.
//     An accept that makes sample_idx==FRAME_LEN -> FULL.
//     Zero-latency accept; one sample per cycle max.
//   FULL:
//     in_ready=0, frame_valid=1.
//     frame_strobe cycle -> next edge: sample_idx=FRAME_LEN-HOP_LEN, frame_num+=1, state=FILL.
//     First new sample is accepted the cycle after frame_strobe.
//     in_valid=1 in FULL (or in FILL never) sets overrun=1 next edge.
//     The sample is not consumed (upstream must hold it).
//   HOP_LEN==FRAME_LEN: sample_idx restarts at 0 (legacy 48/48 behaviour).
//   frame_num wraps 2^FRAME_CNT_W-1 -> 0 with no flag.
//   enable=0 in any state -> IDLE next edge.
//     sample_idx cleared to 0 (partial frame discarded); frame_num and overrun kept.
//     If frame_strobe occurs in the same cycle, the transfer counts (frame_num+=1) before the clear.
//   sync_clear=1: next edge sample_idx=0, frame_num=0, overrun=0.
//     State -> FILL if enable else IDLE.
//     Priority over accept, transfer and overrun set in that cycle; frame_strobe may still pulse combinationally.
//   in_valid may toggle freely; no combinational path from fft_ready to in_ready.
//   sample_idx never exceeds FRAME_LEN; all counters saturate-free by construction.
// STRUCTURE
//   Shared package fft_seq_pkg: seq_state_t enum {IDLE, FILL, FULL} and a default FFT_FRAME_LEN=48 constant.
//   One sub-module is natural: flex_counter instance for sample_idx.
//     It is extended with a load/load_val port for the overlap restart value.
//   frame_num is a plain register.
// TESTING
//   1 Reset, enable=1, 48 back-to-back samples, fft_ready=1 -> sample_idx 0..48, frame_valid in cycle 49, frame_strobe 1 cycle, frame_num=1, sample_idx=0.
//   2 FRAME_LEN=8, HOP_LEN=2, fft_ready=1, continuous input -> first frame after 8 accepts, then frame_strobe every 2 accepts (+1 FULL cycle), sample_idx restarts at 6.
//   3 Full frame, fft_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, no sample_shift, overrun=1 sticky; after fft_ready=1 one frame_strobe, FILL resumes.
//   4 enable dropped at sample_idx=20 -> IDLE, sample_idx=0, frame_num unchanged; re-enable and 48 samples -> frame_strobe as test 1.
//   5 sync_clear coincident with accept and overrun -> sample_idx=0, frame_num=0, overrun=0 next cycle; async n_reset pulse mid-FULL -> all outputs reset immediately.
//   6 FRAME_CNT_W=2, 5 frames -> frame_num 1,2,3,0,1.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT front-end input sequencer.
// Holds the sequencer state type and the default frame length.
package fft_seq_pkg;

  localparam int FFT_FRAME_LEN = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } seq_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and parallel load.
// Priority order: clear, then load, then count.
module flex_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sample_frame_sequencer.sv
// Counts handshaked input samples into (optionally overlapped) frames and
// hands each full frame to the FFT core, with frame numbering and sticky overrun.
module sample_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FRAME_LEN   = FFT_FRAME_LEN,
  parameter int HOP_LEN     = FRAME_LEN,
  parameter int CNT_W       = $clog2(FRAME_LEN + 1),
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   enable,
  input  logic                   sync_clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   sample_shift,
  output logic [CNT_W-1:0]       sample_idx,
  output logic                   frame_valid,
  input  logic                   fft_ready,
  output logic                   frame_strobe,
  output logic [FRAME_CNT_W-1:0] frame_num,
  output logic                   overrun
);

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] RESTART_IDX = CNT_W'(FRAME_LEN - HOP_LEN);

  seq_state_t             state;
  seq_state_t             state_next;
  logic [FRAME_CNT_W-1:0] frame_num_next;
  logic                   overrun_next;

  // Ready/valid depend only on registered state, so fft_ready never reaches in_ready.
  assign in_ready     = (state == FILL);
  assign frame_valid  = (state == FULL);
  assign sample_shift = in_valid & in_ready;
  assign frame_strobe = frame_valid & fft_ready;

  // Dropping enable discards the partial frame; a transfer reloads the overlap.
  flex_counter #(
    .WIDTH(CNT_W)
  ) u_sample_cnt (
    .clk         (clk),
    .n_reset     (n_reset),
    .clear       (sync_clear | ~enable),
    .count_enable(sample_shift),
    .load        (frame_strobe),
    .load_val    (RESTART_IDX),
    .count       (sample_idx)
  );

  always_comb begin
    state_next     = state;
    frame_num_next = frame_num;
    overrun_next   = overrun;

    if (frame_strobe) begin
      frame_num_next = frame_num + 1'b1;
    end
    if (frame_valid && in_valid) begin
      overrun_next = 1'b1;
    end

    case (state)
      IDLE:    state_next = FILL;
      FILL:    if (sample_shift && sample_idx == LAST_IDX) state_next = FULL;
      FULL:    if (fft_ready) state_next = FILL;
      default: state_next = IDLE;
    endcase

    if (!enable) begin
      state_next = IDLE;
    end

    // Clear outranks every other update made in the same cycle.
    if (sync_clear) begin
      state_next     = enable ? FILL : IDLE;
      frame_num_next = '0;
      overrun_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      frame_num <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      frame_num <= frame_num_next;
      overrun   <= overrun_next;
    end
  end

endmodule
